// File: rtl/arm_sram_bridge.sv
// ---------------------------------------------------------------------------
// arm_sram_bridge
//
// Purpose:
//   Clocked bridge between the ARM static-memory bus and an 8-bit asynchronous
//   SRAM. The ARM strobes are synchronised into the CLK domain. Each ARM access
//   of ARM_DW bits is split into ARM_DW/8 byte-wide SRAM cycles:
//   SETUP (1 cycle), STROBE (WAIT+1 cycles) and HOLD (1 cycle).
//   Write beats whose byte enable is inactive are skipped at zero cost.
//   The ARM is stalled through ARM_nWAIT until the whole access is done.
//
// Ports:
//   CLK, nRESET   clock and asynchronous active-low reset
//   ARM_D         ARM data bus; driven with the read data only during a read
//   ARM_A         ARM word address, sampled at access start
//   ARM_nBE       active-low byte enables; bit k covers ARM_D[8k+7:8k]
//   ARM_nCS/nOE/nWE  ARM strobes, asynchronous to CLK
//   ARM_nWAIT     low while the ARM must hold the current access
//   SRAM_D        SRAM data; driven only during the beats of a write
//   SRAM_A        SRAM byte address {word address, beat}
//   SRAM_nCS/nOE/nWE  registered SRAM strobes
//   BUSY          high whenever the FSM is not IDLE
//   DBG_STATE     current FSM state, for debug and checkers
//
// ARM handshake: an access is requested by holding ARM_nCS low together with
// ARM_nOE or ARM_nWE (write wins if both are low). The request is accepted
// once the synchronised strobes are seen in IDLE. ARM_nWAIT then stays low
// until the FSM reaches DONE. The ARM must keep its strobes and write data
// stable until ARM_nWAIT rises, and must raise ARM_nCS before it issues the
// next access.
// ---------------------------------------------------------------------------
module arm_sram_bridge #(
    parameter int ARM_DW = 16,
    parameter int AW     = 19,
    parameter int WAIT   = 2,
    localparam int R     = ARM_DW / 8,
    localparam int LR    = (R > 1) ? $clog2(R) : 0,
    localparam int SAW   = AW + LR
) (
    input  logic              CLK,
    input  logic              nRESET,
    inout  wire  [ARM_DW-1:0] ARM_D,
    input  logic [AW-1:0]     ARM_A,
    input  logic [R-1:0]      ARM_nBE,
    input  logic              ARM_nCS,
    input  logic              ARM_nOE,
    input  logic              ARM_nWE,
    output logic              ARM_nWAIT,
    inout  wire  [7:0]        SRAM_D,
    output logic [SAW-1:0]    SRAM_A,
    output logic              SRAM_nCS,
    output logic              SRAM_nOE,
    output logic              SRAM_nWE,
    output logic              BUSY,
    output logic [2:0]        DBG_STATE
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Strobe synchronisers.
    // The chip-select chain resets to "asserted" so that a chip select that
    // is still low when reset is released is not taken as a fresh access.
    // ------------------------------------------------------------------
    logic [1:0] cs_sync_q;
    logic [1:0] oe_sync_q;
    logic [1:0] we_sync_q;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            cs_sync_q <= 2'b00;
            oe_sync_q <= 2'b11;
            we_sync_q <= 2'b11;
        end else begin
            cs_sync_q <= {cs_sync_q[0], ARM_nCS};
            oe_sync_q <= {oe_sync_q[0], ARM_nOE};
            we_sync_q <= {we_sync_q[0], ARM_nWE};
        end
    end

    // Active-high synchronised strobes.
    logic s_cs;
    logic s_oe;
    logic s_we;
    assign s_cs = ~cs_sync_q[1];
    assign s_oe = ~oe_sync_q[1];
    assign s_we = ~we_sync_q[1];

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------
    // Lowest beat index >= from that must be performed; R when none is left.
    // Reads perform every beat, writes only the byte-enabled ones.
    function automatic logic [2:0] find_beat(input logic [R-1:0] nbe,
                                             input logic         wr,
                                             input logic [2:0]   from);
        logic [2:0] res;
        res = 3'(R);
        for (int k = R - 1; k >= 0; k--) begin
            if (k >= int'(from) && (!wr || !nbe[k])) begin
                res = 3'(k);
            end
        end
        return res;
    endfunction

    // SRAM byte address of beat k: {word address, k}, little-endian lanes.
    function automatic logic [SAW-1:0] beat_addr(input logic [AW-1:0] a,
                                                 input logic [2:0]    k);
        logic [SAW-1:0] res;
        res = SAW'(a) << LR;
        res = res | (SAW'(k) & SAW'(R - 1));
        return res;
    endfunction

    function automatic logic [7:0] pick_byte(input logic [ARM_DW-1:0] w,
                                             input logic [2:0]        k);
        logic [7:0] res;
        res = 8'h00;
        for (int i = 0; i < R; i++) begin
            if (int'(k) == i) begin
                res = w[8*i +: 8];
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // FSM and registered outputs
    // ------------------------------------------------------------------
    state_t            state_q;
    logic              armed_q;     // chip select seen high since reset
    logic              wr_q;
    logic [AW-1:0]     addr_q;
    logic [ARM_DW-1:0] wdata_q;
    logic [R-1:0]      nbe_q;
    logic [ARM_DW-1:0] rdata_q;
    logic [2:0]        beat_q;
    logic [3:0]        wait_q;
    logic [SAW-1:0]    sram_a_q;
    logic [7:0]        sram_dout_q;
    logic              sram_d_oe_q;
    logic              sram_ncs_q;
    logic              sram_noe_q;
    logic              sram_nwe_q;

    logic              start_d;
    logic [2:0]        first_beat_d;
    logic [2:0]        next_beat_d;

    assign start_d      = armed_q && s_cs && (s_we || s_oe);
    assign first_beat_d = find_beat(ARM_nBE, s_we, 3'd0);
    assign next_beat_d  = find_beat(nbe_q, wr_q, beat_q + 3'd1);

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q     <= ST_IDLE;
            armed_q     <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            nbe_q       <= '1;
            rdata_q     <= '0;
            beat_q      <= '0;
            wait_q      <= '0;
            sram_a_q    <= '0;
            sram_dout_q <= '0;
            sram_d_oe_q <= 1'b0;
            sram_ncs_q  <= 1'b1;
            sram_noe_q  <= 1'b1;
            sram_nwe_q  <= 1'b1;
        end else begin
            if (!s_cs) begin
                armed_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_d) begin
                        addr_q  <= ARM_A;
                        wdata_q <= ARM_D;
                        nbe_q   <= ARM_nBE;
                        wr_q    <= s_we;
                        rdata_q <= '0;
                        if (first_beat_d == 3'(R)) begin
                            // Write with every byte disabled: nothing to do.
                            state_q <= ST_DONE;
                        end else begin
                            beat_q      <= first_beat_d;
                            sram_a_q    <= beat_addr(ARM_A, first_beat_d);
                            sram_dout_q <= pick_byte(ARM_D, first_beat_d);
                            sram_d_oe_q <= s_we;
                            sram_ncs_q  <= 1'b0;
                            state_q     <= ST_SETUP;
                        end
                    end
                end

                ST_SETUP: begin
                    wait_q <= '0;
                    if (wr_q) begin
                        sram_nwe_q <= 1'b0;
                    end else begin
                        sram_noe_q <= 1'b0;
                    end
                    state_q <= ST_STROBE;
                end

                ST_STROBE: begin
                    if (wait_q == 4'(WAIT)) begin
                        sram_noe_q <= 1'b1;
                        sram_nwe_q <= 1'b1;
                        if (!wr_q) begin
                            for (int i = 0; i < R; i++) begin
                                if (int'(beat_q) == i) begin
                                    rdata_q[8*i +: 8] <= SRAM_D;
                                end
                            end
                        end
                        state_q <= ST_HOLD;
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
                end

                ST_HOLD: begin
                    if (next_beat_d == 3'(R)) begin
                        sram_ncs_q  <= 1'b1;
                        sram_d_oe_q <= 1'b0;
                        state_q     <= ST_DONE;
                    end else begin
                        // Chip select stays low across beats; address and
                        // data change while both strobes are high.
                        beat_q      <= next_beat_d;
                        sram_a_q    <= beat_addr(addr_q, next_beat_d);
                        sram_dout_q <= pick_byte(wdata_q, next_beat_d);
                        state_q     <= ST_SETUP;
                    end
                end

                ST_DONE: begin
                    if (!s_cs) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign SRAM_A    = sram_a_q;
    assign SRAM_nCS  = sram_ncs_q;
    assign SRAM_nOE  = sram_noe_q;
    assign SRAM_nWE  = sram_nwe_q;
    assign BUSY      = (state_q != ST_IDLE);
    assign DBG_STATE = state_q;

    assign SRAM_D = sram_d_oe_q ? sram_dout_q : 8'bz;

    // Read data goes straight out on the raw ARM strobes so the bus is
    // released as soon as the ARM lifts nCS or nOE, without sync delay.
    assign ARM_D = (nRESET && !ARM_nCS && !ARM_nOE && !wr_q) ? rdata_q
                                                             : {ARM_DW{1'bz}};

    assign ARM_nWAIT = ~(nRESET && !ARM_nCS && (state_q != ST_DONE));

endmodule
